// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the MIPS register-file write port.
// Queues write-back requests, drains one per cycle, and forwards pending data to both read ports.
module regfile_write_buffer #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid_i,
    output logic                   wb_ready_o,
    input  logic [4:0]             wb_reg_i,
    input  logic [N-1:0]           wb_data_i,
    input  logic                   flush_i,
    input  logic                   rf_stall_i,
    output logic                   Reg_Write_o,
    output logic [4:0]             Write_Register_o,
    output logic [N-1:0]           Write_Data_o,
    input  logic [4:0]             Read_Register_1_i,
    input  logic [4:0]             Read_Register_2_i,
    output logic                   Fwd_Hit_1_o,
    output logic [N-1:0]           Fwd_Data_1_o,
    output logic                   Fwd_Hit_2_o,
    output logic [N-1:0]           Fwd_Data_2_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       reg_q  [DEPTH];
    logic [4:0]       reg_d  [DEPTH];
    logic [N-1:0]     data_q [DEPTH];
    logic [N-1:0]     data_d [DEPTH];

    logic             empty;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] fwd_idx;

    assign empty      = (count_q == '0);
    assign wb_ready_o = (count_q < CNT_W'(DEPTH));
    // Writes to $zero complete the handshake but are dropped here.
    assign push       = wb_valid_i & wb_ready_o & (wb_reg_i != 5'd0);
    assign pop        = !empty & !rf_stall_i;

    assign Reg_Write_o      = pop;
    assign Write_Register_o = empty ? 5'd0 : reg_q[rd_ptr_q];
    assign Write_Data_o     = empty ? '0 : data_q[rd_ptr_q];
    assign count_o          = count_q;
    assign empty_o          = empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        reg_d    = reg_q;
        data_d   = data_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            valid_d  = '0;
        end else begin
            if (pop) begin
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + 1'b1;
            end
            if (push) begin
                valid_d[wr_ptr_q] = 1'b1;
                reg_d[wr_ptr_q]   = wb_reg_i;
                data_d[wr_ptr_q]  = wb_data_i;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match, the youngest write, wins.
    always_comb begin
        Fwd_Hit_1_o  = 1'b0;
        Fwd_Data_1_o = '0;
        Fwd_Hit_2_o  = 1'b0;
        Fwd_Data_2_o = '0;
        fwd_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + PTR_W'(i);
            if (valid_q[fwd_idx] && (Read_Register_1_i != 5'd0) &&
                (reg_q[fwd_idx] == Read_Register_1_i)) begin
                Fwd_Hit_1_o  = 1'b1;
                Fwd_Data_1_o = data_q[fwd_idx];
            end
            if (valid_q[fwd_idx] && (Read_Register_2_i != 5'd0) &&
                (reg_q[fwd_idx] == Read_Register_2_i)) begin
                Fwd_Hit_2_o  = 1'b1;
                Fwd_Data_2_o = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            reg_q    <= reg_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the pending writes.
module tb_regfile_write_buffer;
    localparam int N     = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]   r;
        logic [N-1:0] d;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         wb_valid_i = 1'b0;
    logic         wb_ready_o;
    logic [4:0]   wb_reg_i = '0;
    logic [N-1:0] wb_data_i = '0;
    logic         flush_i = 1'b0;
    logic         rf_stall_i = 1'b0;
    logic         Reg_Write_o;
    logic [4:0]   Write_Register_o;
    logic [N-1:0] Write_Data_o;
    logic [4:0]   Read_Register_1_i = '0;
    logic [4:0]   Read_Register_2_i = '0;
    logic         Fwd_Hit_1_o;
    logic [N-1:0] Fwd_Data_1_o;
    logic         Fwd_Hit_2_o;
    logic [N-1:0] Fwd_Data_2_o;
    logic [2:0]   count_o;
    logic         empty_o;

    int checks = 0;
    int errors = 0;

    ent_t mq[$];

    regfile_write_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid_i       (wb_valid_i),
        .wb_ready_o       (wb_ready_o),
        .wb_reg_i         (wb_reg_i),
        .wb_data_i        (wb_data_i),
        .flush_i          (flush_i),
        .rf_stall_i       (rf_stall_i),
        .Reg_Write_o      (Reg_Write_o),
        .Write_Register_o (Write_Register_o),
        .Write_Data_o     (Write_Data_o),
        .Read_Register_1_i(Read_Register_1_i),
        .Read_Register_2_i(Read_Register_2_i),
        .Fwd_Hit_1_o      (Fwd_Hit_1_o),
        .Fwd_Data_1_o     (Fwd_Data_1_o),
        .Fwd_Hit_2_o      (Fwd_Hit_2_o),
        .Fwd_Data_2_o     (Fwd_Data_2_o),
        .count_o          (count_o),
        .empty_o          (empty_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle with the given request; request and flush drop back to idle afterwards.
    task automatic apply_stimulus(input logic v, input logic [4:0] r, input logic [N-1:0] d, input logic f);
        wb_valid_i = v;
        wb_reg_i   = r;
        wb_data_i  = d;
        flush_i    = f;
        @(posedge clk);
        #1;
        wb_valid_i = 1'b0;
        wb_reg_i   = '0;
        wb_data_i  = '0;
        flush_i    = 1'b0;
    endtask

    always @(negedge reset) mq.delete();

    // Model: pending writes are a plain FIFO of {reg, data}.
    logic m_pop;
    logic m_push;
    always @(posedge clk) begin
        if (reset) begin
            m_pop  = (mq.size() > 0) && !rf_stall_i;
            m_push = wb_valid_i && (mq.size() < DEPTH) && (wb_reg_i != 5'd0);
            if (flush_i) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back('{r: wb_reg_i, d: wb_data_i});
            end
        end
    end

    logic         e_hit1, e_hit2;
    logic [N-1:0] e_dat1, e_dat2;
    always @(negedge clk) begin
        e_hit1 = 1'b0;
        e_hit2 = 1'b0;
        e_dat1 = '0;
        e_dat2 = '0;
        foreach (mq[i]) begin
            if (Read_Register_1_i != 5'd0 && mq[i].r == Read_Register_1_i) begin
                e_hit1 = 1'b1;
                e_dat1 = mq[i].d;
            end
            if (Read_Register_2_i != 5'd0 && mq[i].r == Read_Register_2_i) begin
                e_hit2 = 1'b1;
                e_dat2 = mq[i].d;
            end
        end
        check_output("cmp_ready", 32'(wb_ready_o), 32'(mq.size() < DEPTH));
        check_output("cmp_count", 32'(count_o), 32'(mq.size()));
        check_output("cmp_empty", 32'(empty_o), 32'(mq.size() == 0));
        check_output("cmp_regwrite", 32'(Reg_Write_o), 32'((mq.size() > 0) && !rf_stall_i));
        check_output("cmp_wreg", 32'(Write_Register_o), (mq.size() > 0) ? 32'(mq[0].r) : 32'd0);
        check_output("cmp_wdata", Write_Data_o, (mq.size() > 0) ? mq[0].d : 32'd0);
        check_output("cmp_hit1", 32'(Fwd_Hit_1_o), 32'(e_hit1));
        check_output("cmp_fdata1", Fwd_Data_1_o, e_dat1);
        check_output("cmp_hit2", 32'(Fwd_Hit_2_o), 32'(e_hit2));
        check_output("cmp_fdata2", Fwd_Data_2_o, e_dat2);
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ready", 32'(wb_ready_o), 32'd1);
        check_output("reset_empty", 32'(empty_o), 32'd1);
        check_output("reset_regwrite", 32'(Reg_Write_o), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] single write");
        apply_stimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        check_output("single_regwrite", 32'(Reg_Write_o), 32'd1);
        check_output("single_wreg", 32'(Write_Register_o), 32'd5);
        check_output("single_wdata", Write_Data_o, 32'hDEADBEEF);
        apply_stimulus(1'b0, 5'd0, '0, 1'b0);
        check_output("single_empty", 32'(empty_o), 32'd1);

        $display("[TB] fill under stall");
        rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 5'(i), 32'(i * 'h11), 1'b0);
        check_output("fill_count", 32'(count_o), 32'd4);
        check_output("fill_ready", 32'(wb_ready_o), 32'd0);
        apply_stimulus(1'b1, 5'd9, 32'h55, 1'b0);
        check_output("fill_fifth_ignored", 32'(count_o), 32'd4);
        rf_stall_i = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            check_output("fill_drain_we", 32'(Reg_Write_o), 32'd1);
            check_output("fill_drain_reg", 32'(Write_Register_o), 32'(i));
            check_output("fill_drain_data", Write_Data_o, 32'(i * 'h11));
            apply_stimulus(1'b0, 5'd0, '0, 1'b0);
        end
        check_output("fill_drained", 32'(empty_o), 32'd1);

        $display("[TB] zero register");
        Read_Register_1_i = 5'd0;
        check_output("zero_ready", 32'(wb_ready_o), 32'd1);
        apply_stimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        check_output("zero_count", 32'(count_o), 32'd0);
        check_output("zero_regwrite", 32'(Reg_Write_o), 32'd0);
        check_output("zero_hit", 32'(Fwd_Hit_1_o), 32'd0);

        $display("[TB] youngest wins");
        rf_stall_i = 1'b1;
        apply_stimulus(1'b1, 5'd7, 32'hA, 1'b0);
        apply_stimulus(1'b1, 5'd7, 32'hB, 1'b0);
        Read_Register_1_i = 5'd7;
        #1;
        check_output("young_hit", 32'(Fwd_Hit_1_o), 32'd1);
        check_output("young_data", Fwd_Data_1_o, 32'hB);
        rf_stall_i = 1'b0;
        #1;
        check_output("young_head", Write_Data_o, 32'hA);
        apply_stimulus(1'b0, 5'd0, '0, 1'b0);
        check_output("young_hit_after1", 32'(Fwd_Hit_1_o), 32'd1);
        check_output("young_data_after1", Fwd_Data_1_o, 32'hB);
        apply_stimulus(1'b0, 5'd0, '0, 1'b0);
        check_output("young_hit_after2", 32'(Fwd_Hit_1_o), 32'd0);

        $display("[TB] push and pop at full");
        rf_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 5'(10 + i), 32'(16'hC0 + i), 1'b0);
        check_output("full_count", 32'(count_o), 32'd4);
        rf_stall_i = 1'b0;
        apply_stimulus(1'b1, 5'd14, 32'hE, 1'b0);
        check_output("full_refused_count", 32'(count_o), 32'd3);
        check_output("full_refused_ready", 32'(wb_ready_o), 32'd1);
        check_output("full_head", 32'(Write_Register_o), 32'd11);
        apply_stimulus(1'b1, 5'd15, 32'hF, 1'b0);
        check_output("pushpop_count", 32'(count_o), 32'd3);
        check_output("pushpop_head", 32'(Write_Register_o), 32'd12);
        repeat (3) apply_stimulus(1'b0, 5'd0, '0, 1'b0);
        check_output("pushpop_drained", 32'(empty_o), 32'd1);

        $display("[TB] flush and async reset");
        rf_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 5'(20 + i), 32'(i + 1), 1'b0);
        check_output("flush_pre_count", 32'(count_o), 32'd3);
        apply_stimulus(1'b0, 5'd0, '0, 1'b1);
        check_output("flush_count", 32'(count_o), 32'd0);
        rf_stall_i = 1'b0;
        #1;
        check_output("flush_no_write", 32'(Reg_Write_o), 32'd0);
        rf_stall_i = 1'b1;
        apply_stimulus(1'b1, 5'd3, 32'h33, 1'b0);
        apply_stimulus(1'b1, 5'd4, 32'h44, 1'b0);
        check_output("requeue_count", 32'(count_o), 32'd2);
        rf_stall_i = 1'b0;
        Read_Register_2_i = 5'd4;
        #1;
        check_output("requeue_hit2", 32'(Fwd_Hit_2_o), 32'd1);
        reset = 1'b0;
        #1;
        check_output("areset_count", 32'(count_o), 32'd0);
        check_output("areset_regwrite", 32'(Reg_Write_o), 32'd0);
        check_output("areset_wdata", Write_Data_o, 32'd0);
        check_output("areset_hit2", 32'(Fwd_Hit_2_o), 32'd0);
        check_output("areset_ready", 32'(wb_ready_o), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            Read_Register_1_i = 5'($urandom_range(7));
            Read_Register_2_i = 5'($urandom_range(7));
            rf_stall_i        = ($urandom_range(99) < 30);
            if ($urandom_range(199) == 0) begin
                reset = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
            end else begin
                apply_stimulus($urandom_range(99) < 60, 5'($urandom_range(7)), $urandom,
                               $urandom_range(99) < 3);
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Producer side of the register-file write port for the multicycle MIPS core.
- Accepts write-back requests from the datapath through a valid/ready handshake and queues them in a small FIFO.
- Drains one queued write per cycle onto the register file's Reg_Write/Write_Register/Write_Data inputs.
- Forwards pending (queued, not yet written) data to the two register read addresses, so reads never return stale values.

Parameters:
- N, 32, data width of the register file.
- DEPTH, 4, number of queued writes (power of 2, minimum 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- wb_valid_i  input  1  write-back request valid.
- wb_ready_o  output  1  buffer can accept a request.
- wb_reg_i  input  5  destination register number.
- wb_data_i  input  N  write-back data.
- flush_i  input  1  synchronous clear of all queued entries.
- rf_stall_i  input  1  holds the drain; no write is issued while high.
- Reg_Write_o  output  1  register-file write enable.
- Write_Register_o  output  5  register-file write address.
- Write_Data_o  output  N  register-file write data.
- Read_Register_1_i  input  5  read address 1, shared with the register file.
- Read_Register_2_i  input  5  read address 2, shared with the register file.
- Fwd_Hit_1_o  output  1  address 1 matches a pending entry.
- Fwd_Data_1_o  output  N  forwarded data for address 1.
- Fwd_Hit_2_o  output  1  address 2 matches a pending entry.
- Fwd_Data_2_o  output  N  forwarded data for address 2.
- count_o  output  clog2(DEPTH)+1  number of queued entries.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - Read/write pointers = 0, count = 0, all entry valids = 0.
  - Outputs: wb_ready_o=1, Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, Fwd_Hit_x_o=0, Fwd_Data_x_o=0, count_o=0, empty_o=1.
  - Reset mid-operation discards all queued writes; none reach the register file.
- wb_ready_o = (count < DEPTH). It is purely a function of registered count and does not depend on same-cycle drain.
- Push: wb_valid_i & wb_ready_o at a clock edge.
  - Entry {wb_reg_i, wb_data_i} written at the tail; tail increments, wrapping modulo DEPTH.
  - A request with wb_reg_i==0 is accepted (handshake completes) but not enqueued; $zero is never written.
- Drain: combinational from the head entry.
  - Reg_Write_o = !empty & !rf_stall_i.
  - Write_Register_o and Write_Data_o show the head entry whenever non-empty; they are 0 when empty.
  - The head pops at the edge where Reg_Write_o=1, and the register file captures the value at that same edge.
- Latency: a push into an empty buffer appears on Reg_Write_o in the next cycle.
  - Minimum accept-to-register-file-update is 2 edges.
- Ordering is strict FIFO. Two queued writes to the same register reach the file in acceptance order.
- Simultaneous push and pop: count is unchanged; pointers both advance. This is legal at any count, including DEPTH-1 and full (full only pops, since ready=0).
- flush_i: at the edge, count=0 and pointers=0.
  - flush_i has priority over push and pop; neither takes effect on that edge.
  - Reg_Write_o is still driven combinationally during the flush cycle. The head write issued in that cycle does complete.
- Forwarding, evaluated independently per port x:
  - Fwd_Hit_x_o = 1 if any valid queued entry (head included) has reg == Read_Register_x_i and Read_Register_x_i != 0.
  - Fwd_Data_x_o = data of the youngest matching entry, or 0 if no hit.
  - The incoming same-cycle wb request is NOT forwarded.
  - The downstream read mux selects Fwd_Data when Fwd_Hit is high, else the register-file data.
- Width rules: count is clog2(DEPTH)+1 bits; pointers are clog2(DEPTH) bits and wrap naturally.
- No overflow or underflow is possible. A push when not ready is ignored with no state change; a pop only occurs when non-empty.

Test Plan:
- Reset then single write: push reg 5 = 0xDEADBEEF. Next cycle Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF. Following cycle empty_o=1.
- Fill under stall: rf_stall_i=1, push regs 1..4 (data 0x11..0x44). Then count_o=4, wb_ready_o=0, and a 5th push is ignored. Release the stall: writes 1,2,3,4 are issued on 4 consecutive cycles.
- $zero suppression: push reg 0 = 0xFFFFFFFF. Handshake completes, count_o stays 0, Reg_Write_o never rises, and a lookup of address 0 gives Fwd_Hit=0.
- Youngest-wins forwarding: stall, push reg 7 = 0xA then reg 7 = 0xB, set Read_Register_1_i=7. Fwd_Hit_1_o=1 and Fwd_Data_1_o=0xB. After the first drain, data is still 0xB. After the second drain, Fwd_Hit_1_o=0.
- Simultaneous push/pop at full: buffer full, release stall and push in the same cycle. The push is refused because wb_ready_o=0 that cycle. Next cycle count=3 and ready=1; a push plus a drain keeps count_o=3.
- Flush and async reset: with 3 queued entries, pulse flush_i, giving count_o=0 and no further writes issued. Re-queue 2 entries and assert reset low mid-cycle: outputs go to reset values immediately, without waiting for clk.
